// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one combinational ALU between
// two requesters. The winning op is latched into operand registers, the ALU
// is driven from them for one cycle (EXEC), and the result is held in a
// response register until the consumer takes it (RESP).
//
// Optional build macro: ALU_SCHED_OP_CHECK_EN
//   defined   -> op codes above MAX_OP produce a zero result with rsp_err=1
//   undefined -> rsp_err tied to 0, every op code passes through unchecked
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   reqN_valid/ready/ctrl/x/y       requester N op handshake (N = 0, 1);
//                                   reqN_ready is combinational
//   alu_ctrl/x/y                    registered operands to the ALU
//   alu_out, alu_carry              ALU result
//   rsp_valid/ready/id/out/carry    response handshake and payload
//   rsp_err                         illegal-op flag
//   op_cnt                          completed responses, saturating
module alu_rr_sched #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned MAX_OP = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req0_x,
  input  logic [WIDTH-1:0]  req0_y,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]  req1_x,
  input  logic [WIDTH-1:0]  req1_y,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [WIDTH-1:0]  alu_x,
  output logic [WIDTH-1:0]  alu_y,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_out,
  output logic              rsp_carry,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  op_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic [WIDTH-1:0]  x_q,         x_d;
  logic [WIDTH-1:0]  y_q,         y_d;
  logic              id_q,        id_d;
  logic              last_q,      last_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0]  rsp_out_q,   rsp_out_d;
  logic              rsp_carry_q, rsp_carry_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
`ifdef ALU_SCHED_OP_CHECK_EN
  logic              rsp_err_q,   rsp_err_d;
`endif

  logic grant_ok;
  logic gnt0;
  logic gnt1;

  // Arbitration: a new grant is allowed in IDLE or on the cycle the pending
  // response is consumed; on a tie the requester not granted last time wins.
  always_comb begin
    grant_ok = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    gnt0     = grant_ok && req0_valid && (!req1_valid || last_q);
    gnt1     = grant_ok && req1_valid && (!req0_valid || !last_q);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Next-state, operand capture and response capture.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    x_d         = x_q;
    y_d         = y_q;
    id_d        = id_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_carry_d = rsp_carry_q;
    cnt_d       = cnt_q;
`ifdef ALU_SCHED_OP_CHECK_EN
    rsp_err_d   = rsp_err_q;
`endif

    if (gnt0 || gnt1) begin
      ctrl_d = gnt1 ? req1_ctrl : req0_ctrl;
      x_d    = gnt1 ? req1_x    : req0_x;
      y_d    = gnt1 ? req1_y    : req0_y;
      id_d   = gnt1;
      last_d = gnt1;
    end

    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_out_d   = alu_out;
        rsp_carry_d = alu_carry;
`ifdef ALU_SCHED_OP_CHECK_EN
        rsp_err_d   = 1'b0;
        if (ctrl_q > CTRL_W'(MAX_OP)) begin
          rsp_out_d   = '0;
          rsp_carry_d = 1'b0;
          rsp_err_d   = 1'b1;
        end
`endif
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = (gnt0 || gnt1) ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; last grant resets to 1 so req0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
      cnt_q       <= '0;
`ifdef ALU_SCHED_OP_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      x_q         <= x_d;
      y_q         <= y_d;
      id_q        <= id_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_carry_q <= rsp_carry_d;
      cnt_q       <= cnt_d;
`ifdef ALU_SCHED_OP_CHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign alu_ctrl  = ctrl_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_carry = rsp_carry_q;
  assign op_cnt    = cnt_q;
`ifdef ALU_SCHED_OP_CHECK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
